program_loader: RTL and testbench

Write-side companion to the program memory. It receives a byte stream over a valid/ready handshake and assembles the bytes into 32-bit instruction words. It then issues one-cycle write strobes into a writable program memory, using byte addresses in the same format the fetch path uses (word index = address >> 2). While a load is in progress it holds the MIPS core stalled, and it reports completion or a framing error.

---
 rtl/program_loader.sv | 145 ++++++++++++++
 tb/tb_program_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: frames a length-prefixed byte stream into 32-bit
// instruction words and writes them into program memory while holding the core.
module program_loader #(
    parameter int MEMORY_DEPTH = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [7:0]            ByteIn,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic                  MemWrite,
    output logic [DATA_WIDTH-1:0] WriteAddress,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  Busy,
    output logic                  CpuHold,
    output logic                  Done,
    output logic                  Error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    // Limit is widened by one bit so a 16-bit length is compared without truncation.
    localparam logic [16:0] MAX_LEN = 17'(MEMORY_DEPTH);
    localparam int          ADDR_PAD = DATA_WIDTH - 18;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           index_q, index_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-9:0] shift_q, shift_d;
    logic                  mem_write_q, mem_write_d;
    logic [DATA_WIDTH-1:0] write_addr_q, write_addr_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;

    logic                  transfer;
    logic [15:0]           n_full;
    logic [15:0]           index_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            index_q      <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            mem_write_q  <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            index_q      <= index_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            mem_write_q  <= mem_write_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        index_d      = index_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        mem_write_d  = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        transfer     = ByteValid && ByteReady;
        n_full       = {len_q[15:8], ByteIn};
        index_inc    = index_q + 16'd1;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (Start) begin
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (transfer) begin
                    len_d[15:8] = ByteIn;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (transfer) begin
                    len_d = n_full;
                    if ((n_full == 16'd0) || ({1'b0, n_full} > MAX_LEN)) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d    = S_DATA;
                        index_d    = '0;
                        byte_cnt_d = '0;
                    end
                end
            end
            S_DATA: begin
                if (transfer) begin
                    shift_d    = {shift_q[DATA_WIDTH-17:0], ByteIn};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // Fourth byte: launch the registered write strobe on this same edge.
                    if (byte_cnt_q == 2'd3) begin
                        mem_write_d  = 1'b1;
                        write_addr_d = {{ADDR_PAD{1'b0}}, index_q, 2'b00};
                        write_data_d = {shift_q, ByteIn};
                        state_d      = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                index_d    = index_inc;
                byte_cnt_d = '0;
                if (index_inc == len_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ByteReady    = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
    assign Busy         = ByteReady || (state_q == S_WRITE);
    assign CpuHold      = Busy;
    assign Done         = (state_q == S_DONE);
    assign Error        = (state_q == S_ERROR);
    assign MemWrite     = mem_write_q;
    assign WriteAddress = write_addr_q;
    assign WriteData    = write_data_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as words are
// streamed in and checked by a monitor whenever MemWrite is seen.
module tb_program_loader;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic        MemWrite;
    logic [31:0] WriteAddress;
    logic [31:0] WriteData;
    logic        Busy;
    logic        CpuHold;
    logic        Done;
    logic        Error;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          write_count = 0;
    int          exp_index = 0;
    logic [31:0] last_addr = '0;

    program_loader #(.MEMORY_DEPTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .Start(Start), .ByteIn(ByteIn),
        .ByteValid(ByteValid), .ByteReady(ByteReady), .MemWrite(MemWrite),
        .WriteAddress(WriteAddress), .WriteData(WriteData), .Busy(Busy),
        .CpuHold(CpuHold), .Done(Done), .Error(Error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (MemWrite === 1'b1) begin
            exp_t e;
            write_count++;
            last_addr = WriteAddress;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h", WriteAddress, WriteData);
            end else begin
                e = exp_q.pop_front();
                if (WriteAddress !== e.addr || WriteData !== e.data) begin
                    errors++;
                    $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                             WriteAddress, WriteData, e.addr, e.data);
                end else begin
                    $display("write addr=%h data=%h ok", WriteAddress, WriteData);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got;
        ByteValid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        ByteValid = 1'b1;
        ByteIn    = b;
        got       = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (ByteReady === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL byte_timeout got ByteReady=%b expected 1", ByteReady);
        end
        @(posedge clk); #1;
        ByteValid = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        exp_index   = 0;
        write_count = 0;
    endtask

    task automatic send_len(input logic [15:0] n, input int gap);
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        exp_t e;
        e.addr = 32'(exp_index) * 32'd4;
        e.data = w;
        exp_q.push_back(e);
        exp_index++;
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    // Called right after the last byte's transfer edge: strobe now, Done one cycle later.
    task automatic check_completion(input string name, input int n_writes);
        @(negedge clk);
        checks++;
        if (MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL %s_strobe got MemWrite=%b expected 1", name, MemWrite);
        end
        @(negedge clk);
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0 || CpuHold !== 1'b0 || Error !== 1'b0) begin
            errors++;
            $display("FAIL %s_done got Done=%b Busy=%b CpuHold=%b Error=%b expected 1 0 0 0",
                     name, Done, Busy, CpuHold, Error);
        end
        checks++;
        if (write_count != n_writes || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_count got writes=%0d pending=%0d expected writes=%0d pending=0",
                     name, write_count, exp_q.size(), n_writes);
        end
        $display("%s: writes=%0d Done=%b", name, write_count, Done);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; Start = 1'b0; ByteValid = 1'b0; ByteIn = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({ByteReady, MemWrite, Busy, CpuHold, Done, Error} !== 6'b0 ||
            WriteAddress !== 32'h0 || WriteData !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got ctl=%b addr=%h data=%h expected all 0",
                     {ByteReady, MemWrite, Busy, CpuHold, Done, Error}, WriteAddress, WriteData);
        end
        $display("reset: ctl=%b", {ByteReady, MemWrite, Busy, CpuHold, Done, Error});
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        pulse_start();
        checks++;
        if (Busy !== 1'b1 || ByteReady !== 1'b1 || Done !== 1'b0) begin
            errors++;
            $display("FAIL basic_start got Busy=%b ByteReady=%b Done=%b expected 1 1 0",
                     Busy, ByteReady, Done);
        end
        send_len(16'h0002, 0);
        send_word(32'h20080005, 0);
        send_word(32'h20090007, 0);
        check_completion("basic", 2);
    endtask

    task automatic test_backpressure();
        pulse_start();
        send_len(16'h0002, 3);
        send_word(32'h20080005, 3);
        send_word(32'h20090007, 3);
        check_completion("backpressure", 2);
        checks++;
        if (WriteAddress !== 32'h4 || WriteData !== 32'h20090007) begin
            errors++;
            $display("FAIL hold_after_write got addr=%h data=%h expected 00000004 20090007",
                     WriteAddress, WriteData);
        end
    endtask

    task automatic test_len_error(input logic [15:0] n);
        pulse_start();
        send_len(n, 0);
        ByteValid = 1'b1;
        ByteIn    = 8'hAA;
        @(negedge clk);
        checks++;
        if (Error !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0 || ByteReady !== 1'b0) begin
            errors++;
            $display("FAIL len_error_%h got Error=%b Busy=%b Done=%b ByteReady=%b expected 1 0 0 0",
                     n, Error, Busy, Done, ByteReady);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (write_count != 0 || Error !== 1'b1) begin
            errors++;
            $display("FAIL len_error_%h_nowrite got writes=%0d Error=%b expected 0 1",
                     n, write_count, Error);
        end
        $display("len_error N=%h: Error=%b writes=%0d", n, Error, write_count);
        @(posedge clk); #1;
        ByteValid = 1'b0;
    endtask

    task automatic test_full_depth();
        pulse_start();
        checks++;
        if (Error !== 1'b0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_from_error got Error=%b Busy=%b expected 0 1", Error, Busy);
        end
        send_len(16'd32, 0);
        for (int i = 0; i < 32; i++) begin
            send_word(32'h1000_0000 + 32'(i), 0);
        end
        check_completion("full_depth", 32);
        checks++;
        if (last_addr !== 32'h7C) begin
            errors++;
            $display("FAIL full_depth_last_addr got %h expected 0000007c", last_addr);
        end
    endtask

    task automatic test_start_ignored();
        pulse_start();
        send_len(16'h0002, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        @(negedge clk);
        checks++;
        if (Busy !== 1'b1 || ByteReady !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored_state got Busy=%b ByteReady=%b expected 1 1",
                     Busy, ByteReady);
        end
        @(posedge clk); #1;
        begin
            exp_t e;
            e.addr = 32'h0;
            e.data = 32'hABCD_1234;
            exp_q.push_back(e);
            exp_index = 1;
        end
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_word(32'h5566_7788, 0);
        check_completion("start_ignored", 2);
    endtask

    task automatic test_reset_midload();
        pulse_start();
        send_len(16'h0002, 0);
        send_word(32'hCAFE_0001, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({ByteReady, MemWrite, Busy, CpuHold, Done, Error} !== 6'b0 ||
            WriteAddress !== 32'h0 || WriteData !== 32'h0) begin
            errors++;
            $display("FAIL reset_midload got ctl=%b addr=%h data=%h expected all 0",
                     {ByteReady, MemWrite, Busy, CpuHold, Done, Error}, WriteAddress, WriteData);
        end
        checks++;
        if (write_count != 1) begin
            errors++;
            $display("FAIL reset_midload_writes got %0d expected 1", write_count);
        end
        $display("reset_midload: ctl=%b writes=%0d",
                 {ByteReady, MemWrite, Busy, CpuHold, Done, Error}, write_count);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        send_len(16'h0001, 0);
        send_word(32'hDEAD_BEEF, 0);
        check_completion("reload", 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_len_error(16'h0000);
        test_len_error(16'h0021);
        test_len_error(16'h0100);
        test_full_depth();
        test_start_ignored();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
